// File: rtl/button_debouncer.sv
// Debounces N_BTN raw buttons against a slow, asynchronous sample clock and emits
// a clean level plus single-cycle press, release and long-press (hold) pulses.
module button_debouncer #(
    parameter int N_BTN          = 4,
    parameter int STABLE_SAMPLES = 3,
    parameter int HOLD_SAMPLES   = 32,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_clk_in,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic             sample_tick
);

    localparam logic             POLARITY   = (ACTIVE_LOW != 0);
    localparam logic [N_BTN-1:0] IDLE_RAW   = {N_BTN{POLARITY}};
    localparam logic [4:0]       STABLE_CNT = 5'(STABLE_SAMPLES);
    localparam logic [7:0]       HOLD_CNT   = 8'(HOLD_SAMPLES);

    typedef enum logic [1:0] {
        IDLE,
        CONF_PRESS,
        PRESSED,
        CONF_REL
    } state_t;

    logic [N_BTN-1:0] raw_meta_reg;
    logic [N_BTN-1:0] raw_sync_reg;
    logic             smp_meta_reg;
    logic             smp_sync_reg;
    logic             smp_prev_reg;
    logic             sample_tick_reg;
    logic             tick;
    logic [N_BTN-1:0] pressed;

    // Synchronisers reset to the idle (unpressed) pin level so no phantom press follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_meta_reg    <= IDLE_RAW;
            raw_sync_reg    <= IDLE_RAW;
            smp_meta_reg    <= 1'b0;
            smp_sync_reg    <= 1'b0;
            smp_prev_reg    <= 1'b0;
            sample_tick_reg <= 1'b0;
        end else begin
            raw_meta_reg    <= btn_raw;
            raw_sync_reg    <= raw_meta_reg;
            smp_meta_reg    <= sample_clk_in;
            smp_sync_reg    <= smp_meta_reg;
            smp_prev_reg    <= smp_sync_reg;
            sample_tick_reg <= tick;
        end
    end

    assign tick        = smp_sync_reg & ~smp_prev_reg;
    assign pressed     = raw_sync_reg ^ IDLE_RAW;
    assign sample_tick = sample_tick_reg;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t     state_reg, state_next;
            logic [3:0] cnt_reg, cnt_next;
            logic [7:0] hcnt_reg, hcnt_next;
            logic       level_reg, level_next;
            logic       press_reg, press_next;
            logic       release_reg, release_next;
            logic       hold_reg, hold_next;
            logic       p;

            assign p = pressed[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= 4'd0;
                    hcnt_reg    <= 8'd0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    hold_reg    <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    hcnt_reg    <= hcnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                    hold_reg    <= hold_next;
                end
            end

            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                hcnt_next    = hcnt_reg;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                hold_next    = 1'b0;
                if (tick) begin
                    case (state_reg)
                        IDLE: begin
                            if (p) begin
                                state_next = CONF_PRESS;
                                cnt_next   = 4'd1;
                            end
                        end
                        CONF_PRESS: begin
                            if (p) begin
                                if ({1'b0, cnt_reg} + 5'd1 == STABLE_CNT) begin
                                    state_next = PRESSED;
                                    cnt_next   = 4'd0;
                                    hcnt_next  = 8'd0;
                                    level_next = 1'b1;
                                    press_next = 1'b1;
                                end else begin
                                    cnt_next = cnt_reg + 4'd1;
                                end
                            end else begin
                                state_next = IDLE;
                                cnt_next   = 4'd0;
                            end
                        end
                        PRESSED: begin
                            if (p) begin
                                // Saturation makes the hold pulse a one-shot for this press.
                                if (hcnt_reg != HOLD_CNT) begin
                                    hcnt_next = hcnt_reg + 8'd1;
                                    hold_next = (hcnt_reg + 8'd1 == HOLD_CNT);
                                end
                            end else begin
                                state_next = CONF_REL;
                                cnt_next   = 4'd1;
                            end
                        end
                        CONF_REL: begin
                            if (!p) begin
                                if ({1'b0, cnt_reg} + 5'd1 == STABLE_CNT) begin
                                    state_next   = IDLE;
                                    cnt_next     = 4'd0;
                                    level_next   = 1'b0;
                                    release_next = 1'b1;
                                end else begin
                                    cnt_next = cnt_reg + 4'd1;
                                end
                            end else begin
                                // Release glitch: resume the press without restarting hold timing.
                                state_next = PRESSED;
                                cnt_next   = 4'd0;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            cnt_next   = 4'd0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign btn_hold[gi]    = hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a sample-history reference model predicts
// each tick's outputs; a negedge monitor pops and compares whenever sample_tick fires.
module tb_button_debouncer;

    localparam int N    = 4;
    localparam int ST   = 3;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_clk_in = 1'b0;
    logic [N-1:0] btn_raw = 4'hF;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;
    logic         sample_tick;

    button_debouncer #(
        .N_BTN(N), .STABLE_SAMPLES(ST), .HOLD_SAMPLES(HOLD), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_clk_in(sample_clk_in), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_hold(btn_hold), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] hold;
        logic [N-1:0] level;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: accepted level, run of disagreeing samples, pressed-sample count.
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_prev = '0;
    int           m_run[N];
    int           m_hcnt[N];
    logic [N-1:0] last_level = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_level = '0;
        m_prev  = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_hcnt[i] = 0;
        end
    endfunction

    function automatic exp_t model_sample(logic [N-1:0] p, int at);
        exp_t e;
        e.at = at; e.press = '0; e.rel = '0; e.hold = '0;
        for (int i = 0; i < N; i++) begin
            // Hold counts pressed samples that follow a pressed sample while accepted as pressed.
            if (m_level[i] && p[i] && m_prev[i] && m_hcnt[i] < HOLD) begin
                m_hcnt[i]++;
                if (m_hcnt[i] == HOLD) e.hold[i] = 1'b1;
            end
            if (p[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == ST) begin
                    m_level[i] = p[i];
                    m_run[i]   = 0;
                    if (p[i]) begin
                        e.press[i] = 1'b1;
                        m_hcnt[i]  = 0;
                    end else begin
                        e.rel[i] = 1'b1;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            m_prev[i] = p[i];
        end
        e.level = m_level;
        return e;
    endfunction

    task automatic do_tick(input logic [N-1:0] raw, input int high_len);
        exp_t e;
        @(negedge clk);
        btn_raw = raw;
        repeat (3) @(negedge clk);
        sample_clk_in = 1'b1;
        e = model_sample(~raw, cyc);
        q.push_back(e);
        repeat (high_len) @(negedge clk);
        sample_clk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        #1;
        chk({tag, "_level"}, btn_level, 0);
        chk({tag, "_press"}, btn_press, 0);
        chk({tag, "_release"}, btn_release, 0);
        chk({tag, "_hold"}, btn_hold, 0);
        chk({tag, "_tick"}, sample_tick, 0);
    endtask

    // Monitor: pulses only on sample_tick cycles, level steady otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_tick) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick: sample_tick=1 with nothing expected (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("tick cyc=%0d press=%b release=%b hold=%b level=%b", cyc,
                             btn_press, btn_release, btn_hold, btn_level);
                    chk("tick_latency", cyc, e.at + 3);
                    chk("press", btn_press, e.press);
                    chk("release", btn_release, e.rel);
                    chk("hold", btn_hold, e.hold);
                    chk("level", btn_level, e.level);
                    last_level = e.level;
                end
            end else begin
                chk("idle_pulses", btn_press | btn_release | btn_hold, 0);
                chk("idle_level", btn_level, last_level);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // All released, steady ticking.
        repeat (50) do_tick(4'hF, 8);
        // Clean press/release of button 0.
        repeat (4) do_tick(4'hE, 8);
        repeat (4) do_tick(4'hF, 8);
        // Bouncing button 1 then settled pressed.
        for (int k = 0; k < 10; k++) do_tick((k % 2) ? 4'hF : 4'hD, 8);
        repeat (4) do_tick(4'hD, 8);
        // Long press on button 2, then release.
        repeat (14) do_tick(4'h9, 8);
        repeat (4) do_tick(4'hD, 8);
        // Simultaneous press of buttons 0 and 3.
        repeat (4) do_tick(4'h4, 8);
        repeat (4) do_tick(4'hD, 8);
        // Reset during confirmation of button 0 while button 1 is held.
        repeat (2) do_tick(4'hC, 8);
        @(negedge clk);
        rst_n = 1'b0;
        check_outputs_zero("midreset");
        q.delete();
        model_reset();
        last_level = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) do_tick(4'hC, 8);
        // Sample clock stuck low, buttons wiggling: no ticks, no pulses.
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            btn_raw = 4'($urandom);
        end
        // Sample clock stuck high for a long stretch: one tick only.
        do_tick(4'hC, 100);
        // Randomized traffic, each bit flipping with probability 1/4 per tick.
        r = 4'hF;
        for (int k = 0; k < 300; k++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            do_tick(r, 8);
        end
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
